// File: rtl/irq_controller_if.sv
// Bus-side signal bundle for irq_controller.
// Handshake: a register access is qualified by cs together with an active-low
// strobe (rd_n/wr_n); interrupt acknowledge is the CPU holding m1_n and iorq_n
// both low; int_ack is a one-cycle pulse with no back-pressure.
interface irq_controller_if #(
    parameter int unsigned NUM_SRC = 5
);
    logic               cs;
    logic [15:0]        A;
    logic [7:0]         Di;
    logic [7:0]         Do;
    logic               rd_n;
    logic               wr_n;
    logic               m1_n;
    logic               iorq_n;
    logic [NUM_SRC-1:0] int_req;
    logic [NUM_SRC-1:0] int_ack;
    logic               int_n;
    logic [7:0]         jump_addr;

    // CPU/MMU/peripheral side
    modport master (
        output cs, A, Di, rd_n, wr_n, m1_n, iorq_n, int_req,
        input  Do, int_ack, int_n, jump_addr
    );

    // Controller side
    modport slave (
        input  cs, A, Di, rd_n, wr_n, m1_n, iorq_n, int_req,
        output Do, int_ack, int_n, jump_addr
    );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: IF/IE registers, fixed-priority vectoring and per-source
// acknowledge for the TV80 in the Game Boy core. Bit 0 is highest priority.
// Optional macro IRQ_LEVEL_TRIG_EN: requests are level-sensitive (IF[i]
// forced while int_req[i] is high); otherwise rising edges set IF.
module irq_controller #(
    parameter int unsigned NUM_SRC       = 5,
    parameter logic [7:0]  VECTOR_BASE   = 8'h40,
    parameter logic [7:0]  VECTOR_STRIDE = 8'h08,
    parameter logic [15:0] IF_ADDR       = 16'hFF0F,
    parameter logic [15:0] IE_ADDR       = 16'hFFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    irq_controller_if.slave      bus,
    output logic                 dbg_in_ack
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] if_q, if_d;
    logic [NUM_SRC-1:0] int_ack_q, int_ack_d;
    logic [7:0]         ie_q, ie_d;
    logic [7:0]         jump_q, jump_d;
    logic [2:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               ack_prev_q, ack_prev_d;
    logic               wr_prev_q, wr_prev_d;

    logic               ack, ack_rise, ack_fall;
    logic               wr_act, wr_edge;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] set_vec;
    logic               pend_found;
    logic [2:0]         pend_idx;
    logic [7:0]         rd_data;

`ifdef IRQ_LEVEL_TRIG_EN
    assign set_vec = bus.int_req;
`else
    logic [NUM_SRC-1:0] req_prev_q;
    assign set_vec = bus.int_req & ~req_prev_q;
`endif

    assign ack      = !bus.m1_n && !bus.iorq_n;
    assign ack_rise = ack && !ack_prev_q;
    assign ack_fall = !ack && ack_prev_q;
    assign wr_act   = bus.cs && !bus.wr_n;
    assign wr_edge  = wr_act && !wr_prev_q;
    assign pending  = if_q & ie_q[NUM_SRC-1:0];

    // Lowest-numbered pending and enabled source wins.
    always_comb begin
        pend_found = 1'b0;
        pend_idx   = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pend_found = 1'b1;
                pend_idx   = 3'(i);
            end
        end
    end

    // Next-state: CPU write first, then ack clear, then hardware set on top.
    always_comb begin
        state_d    = state_q;
        if_d       = if_q;
        ie_d       = ie_q;
        jump_d     = jump_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        int_ack_d  = '0;
        ack_prev_d = ack;
        wr_prev_d  = wr_act;

        if (wr_edge && bus.A == IF_ADDR) if_d = bus.Di[NUM_SRC-1:0];
        if (wr_edge && bus.A == IE_ADDR) ie_d = bus.Di;

        case (state_q)
            ST_IDLE: begin
                if (ack_rise) begin
                    state_d = ST_ACK;
                    valid_d = pend_found;
                    idx_d   = pend_idx;
                    jump_d  = pend_found ? (VECTOR_BASE + {5'd0, pend_idx} * VECTOR_STRIDE) : 8'h00;
                end
            end
            ST_ACK: begin
                if (ack_fall) begin
                    state_d = ST_IDLE;
                    if (valid_q) begin
                        for (int i = 0; i < NUM_SRC; i++) begin
                            if (idx_q == 3'(i)) begin
                                if_d[i]      = 1'b0;
                                int_ack_d[i] = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if_d = if_d | set_vec;
    end

    // State and register update; reset aborts any acknowledge in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            if_q       <= '0;
            ie_q       <= 8'h00;
            jump_q     <= 8'h00;
            idx_q      <= 3'd0;
            valid_q    <= 1'b0;
            int_ack_q  <= '0;
            ack_prev_q <= 1'b0;
            wr_prev_q  <= 1'b0;
`ifndef IRQ_LEVEL_TRIG_EN
            req_prev_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            if_q       <= if_d;
            ie_q       <= ie_d;
            jump_q     <= jump_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            int_ack_q  <= int_ack_d;
            ack_prev_q <= ack_prev_d;
            wr_prev_q  <= wr_prev_d;
`ifndef IRQ_LEVEL_TRIG_EN
            req_prev_q <= bus.int_req;
`endif
        end
    end

    // Combinational register read; unused IF bits read as 1.
    always_comb begin
        rd_data = 8'hFF;
        if (bus.cs && !bus.rd_n) begin
            if (bus.A == IF_ADDR)      rd_data[NUM_SRC-1:0] = if_q;
            else if (bus.A == IE_ADDR) rd_data = ie_q;
        end
    end

    assign bus.Do        = rd_data;
    assign bus.int_n     = ~(|pending);
    assign bus.int_ack   = int_ack_q;
    assign bus.jump_addr = jump_q;
    assign dbg_in_ack    = (state_q == ST_ACK);

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller (NUM_SRC=5, default vectors and addresses).
module tb_irq_controller;

  localparam logic [15:0] IF_A = 16'hFF0F;
  localparam logic [15:0] IE_A = 16'hFFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic dbg_in_ack;

  irq_controller_if #(.NUM_SRC(5)) bus ();

  irq_controller #(.NUM_SRC(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_in_ack (dbg_in_ack)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] di,
                       input logic [4:0] req, input logic ack);
    bus.cs      = rd | wr;
    bus.rd_n    = ~rd;
    bus.wr_n    = ~wr;
    bus.A       = a;
    bus.Di      = di;
    bus.int_req = req;
    bus.m1_n    = ~ack;
    bus.iorq_n  = ~ack;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 5'd0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // table vectors: inputs held one cycle, outputs sampled after the edge
  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  di;
    logic [4:0]  req;
    logic        ack;
    logic [7:0]  exp_do;
    logic        exp_int_n;
    logic [4:0]  exp_iack;
    logic [7:0]  exp_jump;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] di,
                              input logic [4:0] req, input logic ack, input logic [7:0] edo,
                              input logic eintn, input logic [4:0] eiack, input logic [7:0] ejump);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.di = di; v.req = req; v.ack = ack;
    v.exp_do = edo; v.exp_int_n = eintn; v.exp_iack = eiack; v.exp_jump = ejump;
    return v;
  endfunction

  // behavioural reference model
  logic [4:0] m_if, m_prev_req;
  logic [7:0] m_ie, m_jump;
  bit         m_in_ack, m_valid, m_prev_ack, m_prev_wr;
  int         m_idx;
  logic [4:0] exp_q[$];

  task automatic model_reset();
    m_if = '0; m_prev_req = '0; m_ie = '0; m_jump = '0;
    m_in_ack = 0; m_valid = 0; m_prev_ack = 0; m_prev_wr = 0; m_idx = 0;
    exp_q.delete();
  endtask

  function automatic logic [7:0] model_read();
    if (bus.cs && !bus.rd_n) begin
      if (bus.A == IF_A) return {3'b111, m_if};
      if (bus.A == IE_A) return m_ie;
    end
    return 8'hFF;
  endfunction

  task automatic model_step();
    logic [4:0] set, nxt;
    bit ack_now, wr_now;
    int lowest;
`ifdef IRQ_LEVEL_TRIG_EN
    set = bus.int_req;
`else
    set = bus.int_req & ~m_prev_req;
`endif
    ack_now = !bus.m1_n && !bus.iorq_n;
    wr_now  = bus.cs && !bus.wr_n;
    lowest  = -1;
    for (int i = 4; i >= 0; i--) if (m_if[i] && m_ie[i]) lowest = i;
    nxt = m_if;
    if (wr_now && !m_prev_wr && bus.A == IF_A) nxt = bus.Di[4:0];
    if (wr_now && !m_prev_wr && bus.A == IE_A) m_ie = bus.Di;
    if (m_in_ack && !ack_now) begin
      m_in_ack = 0;
      if (m_valid) begin
        nxt[m_idx] = 1'b0;
        exp_q.push_back(5'(1 << m_idx));
      end
    end else if (!m_in_ack && ack_now && !m_prev_ack) begin
      m_in_ack = 1;
      m_valid  = (lowest >= 0);
      m_idx    = (lowest >= 0) ? lowest : 0;
      m_jump   = (lowest >= 0) ? 8'((64 + lowest * 8) % 256) : 8'h00;
    end
    m_if       = nxt | set;
    m_prev_req = bus.int_req;
    m_prev_ack = ack_now;
    m_prev_wr  = wr_now;
  endtask

  logic ack_lvl;

  initial begin
    // rd wr addr data req ack | Do int_n int_ack jump
    vt[0]  = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hE0, 1, 5'b00000, 8'h00);
    vt[1]  = mk(1, 0, IE_A, 8'h00, 5'b00000, 0, 8'h00, 1, 5'b00000, 8'h00);
    vt[2]  = mk(0, 1, IE_A, 8'h1F, 5'b00000, 0, 8'hFF, 1, 5'b00000, 8'h00);
    vt[3]  = mk(0, 0, IF_A, 8'h00, 5'b00100, 0, 8'hFF, 0, 5'b00000, 8'h00);
    vt[4]  = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hE4, 0, 5'b00000, 8'h00);
    vt[5]  = mk(0, 0, IF_A, 8'h00, 5'b00000, 1, 8'hFF, 0, 5'b00000, 8'h50);
    vt[6]  = mk(0, 0, IF_A, 8'h00, 5'b00000, 1, 8'hFF, 0, 5'b00000, 8'h50);
    vt[7]  = mk(0, 0, IF_A, 8'h00, 5'b00000, 0, 8'hFF, 1, 5'b00100, 8'h50);
    vt[8]  = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hE0, 1, 5'b00000, 8'h50);
    vt[9]  = mk(0, 0, IF_A, 8'h00, 5'b10001, 0, 8'hFF, 0, 5'b00000, 8'h50);
    vt[10] = mk(0, 0, IF_A, 8'h00, 5'b00000, 1, 8'hFF, 0, 5'b00000, 8'h40);
    vt[11] = mk(0, 0, IF_A, 8'h00, 5'b00000, 0, 8'hFF, 0, 5'b00001, 8'h40);
    vt[12] = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hF0, 0, 5'b00000, 8'h40);
    vt[13] = mk(0, 0, IF_A, 8'h00, 5'b00000, 1, 8'hFF, 0, 5'b00000, 8'h60);
    vt[14] = mk(0, 0, IF_A, 8'h00, 5'b00000, 0, 8'hFF, 1, 5'b10000, 8'h60);
    vt[15] = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hE0, 1, 5'b00000, 8'h60);
    vt[16] = mk(0, 1, IE_A, 8'h00, 5'b00000, 0, 8'hFF, 1, 5'b00000, 8'h60);
    vt[17] = mk(0, 0, IF_A, 8'h00, 5'b00000, 0, 8'hFF, 1, 5'b00000, 8'h60);
    vt[18] = mk(0, 1, IF_A, 8'h02, 5'b00000, 0, 8'hFF, 1, 5'b00000, 8'h60);
    vt[19] = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hE2, 1, 5'b00000, 8'h60);
    vt[20] = mk(0, 0, IF_A, 8'h00, 5'b00000, 1, 8'hFF, 1, 5'b00000, 8'h00);
    vt[21] = mk(0, 0, IF_A, 8'h00, 5'b00000, 0, 8'hFF, 1, 5'b00000, 8'h00);
    vt[22] = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hE2, 1, 5'b00000, 8'h00);
    vt[23] = mk(0, 1, IF_A, 8'h00, 5'b01000, 0, 8'hFF, 1, 5'b00000, 8'h00);
    vt[24] = mk(1, 0, IF_A, 8'h00, 5'b00000, 0, 8'hE8, 1, 5'b00000, 8'h00);
    vt[25] = mk(0, 1, IE_A, 8'h1F, 5'b00000, 0, 8'hFF, 0, 5'b00000, 8'h00);
    vt[26] = mk(0, 1, IE_A, 8'h00, 5'b00000, 0, 8'hFF, 0, 5'b00000, 8'h00);
    vt[27] = mk(1, 0, IE_A, 8'h00, 5'b00000, 0, 8'h1F, 0, 5'b00000, 8'h00);

    do_reset();
    check("reset_int_n", 32'(bus.int_n), 32'd1);
    check("reset_int_ack", 32'(bus.int_ack), 32'd0);
    check("reset_jump", 32'(bus.jump_addr), 32'h00);
    check("reset_do", 32'(bus.Do), 32'hFF);
    check("reset_state", 32'(dbg_in_ack), 32'd0);

    for (int r = 0; r < 28; r++) begin
      drive(vt[r].rd, vt[r].wr, vt[r].a, vt[r].di, vt[r].req, vt[r].ack);
      tick();
      check($sformatf("row%0d_do", r), 32'(bus.Do), 32'(vt[r].exp_do));
      check($sformatf("row%0d_int_n", r), 32'(bus.int_n), 32'(vt[r].exp_int_n));
      check($sformatf("row%0d_int_ack", r), 32'(bus.int_ack), 32'(vt[r].exp_iack));
      check($sformatf("row%0d_jump", r), 32'(bus.jump_addr), 32'(vt[r].exp_jump));
    end

    // reset while in ACK: IF=08, IE=1F pending source 3
    drive(0, 0, IF_A, 8'h00, 5'd0, 1);
    tick();
    check("midack_jump", 32'(bus.jump_addr), 32'h58);
    check("midack_state", 32'(dbg_in_ack), 32'd1);
    reset = 1'b1;
    #1;
    check("midack_rst_state", 32'(dbg_in_ack), 32'd0);
    check("midack_rst_int_n", 32'(bus.int_n), 32'd1);
    check("midack_rst_jump", 32'(bus.jump_addr), 32'h00);
    drive(0, 0, IF_A, 8'h00, 5'd0, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midack_no_ack", 32'(bus.int_ack), 32'd0);
    end
    drive(1, 0, IF_A, 8'h00, 5'd0, 0);
    #1;
    check("midack_if", 32'(bus.Do), 32'hE0);

`ifdef IRQ_LEVEL_TRIG_EN
    // level mode: held request survives ack clear and write-0
    drive(0, 1, IE_A, 8'h1F, 5'b00010, 0);
    tick();
    drive(0, 0, IF_A, 8'h00, 5'b00010, 1);
    tick();
    check("lvl_jump", 32'(bus.jump_addr), 32'h48);
    drive(0, 0, IF_A, 8'h00, 5'b00010, 0);
    tick();
    check("lvl_iack", 32'(bus.int_ack), 32'b00010);
    drive(1, 0, IF_A, 8'h00, 5'b00010, 0);
    tick();
    check("lvl_if_held", 32'(bus.Do), 32'hE2);
    drive(0, 1, IF_A, 8'h00, 5'b00010, 0);
    tick();
    drive(1, 0, IF_A, 8'h00, 5'b00010, 0);
    tick();
    check("lvl_if_write_held", 32'(bus.Do), 32'hE2);
    drive(0, 1, IF_A, 8'h00, 5'b00000, 0);
    tick();
    drive(1, 0, IF_A, 8'h00, 5'b00000, 0);
    tick();
    check("lvl_if_cleared", 32'(bus.Do), 32'hE0);
`endif

    // randomized run against the reference model
    do_reset();
    model_reset();
    ack_lvl = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [4:0] exp_iack;
      int sel;
      if ($urandom_range(0, 3) == 0) ack_lvl = ~ack_lvl;
      sel = $urandom_range(0, 3);
      bus.cs      = ($urandom_range(0, 3) != 0);
      bus.A       = (sel < 2) ? IF_A : (sel == 2) ? IE_A : (16'hFF00 + 16'($urandom_range(0, 15)));
      bus.rd_n    = 1'($urandom_range(0, 1));
      bus.wr_n    = ($urandom_range(0, 2) != 0);
      bus.Di      = 8'($urandom_range(0, 255));
      bus.int_req = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      bus.m1_n    = ack_lvl ? 1'b0 : 1'($urandom_range(0, 1));
      bus.iorq_n  = ~ack_lvl;
      #1;
      exp_iack = (exp_q.size() > 0) ? exp_q.pop_front() : 5'd0;
      check("rnd_do", 32'(bus.Do), 32'(model_read()));
      check("rnd_int_n", 32'(bus.int_n), 32'(!(|(m_if & m_ie[4:0]))));
      check("rnd_int_ack", 32'(bus.int_ack), 32'(exp_iack));
      check("rnd_jump", 32'(bus.jump_addr), 32'(m_jump));
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
